fft_bin_magnitude_streamer: RTL

Downstream consumer of the parameterized FFT core. It captures one packed FFT result frame (all bins, real and imaginary) on a single-cycle valid pulse. It then streams per-bin magnitude-squared values one bin per handshake over a valid/ready interface. After the last bin it reports the peak bin index and its magnitude, for use by spectrum-monitor and detection logic.

---
 rtl/fft_bin_magnitude_streamer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fft_bin_magnitude_streamer.sv
// Captures one packed FFT frame, streams per-bin magnitude-squared over valid/ready,
// then reports the peak bin of that frame.
module fft_bin_magnitude_streamer #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned FFT_POINTS      = 8,
    parameter int unsigned LOG2_FFT_POINTS = $clog2(FFT_POINTS),
    parameter int unsigned MAG_WIDTH       = 2 * DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH*FFT_POINTS-1:0] frame_real,
    input  logic [DATA_WIDTH*FFT_POINTS-1:0] frame_imag,
    input  logic                             frame_valid,
    output logic                             bin_valid,
    input  logic                             bin_ready,
    output logic [LOG2_FFT_POINTS-1:0]       bin_index,
    output logic [MAG_WIDTH-1:0]             bin_mag,
    output logic                             bin_last,
    output logic                             peak_valid,
    output logic [LOG2_FFT_POINTS-1:0]       peak_index,
    output logic [MAG_WIDTH-1:0]             peak_mag,
    output logic                             busy,
    output logic                             frame_dropped
);

    typedef enum logic [1:0] {StIdle, StPrep, StStream} state_e;

    localparam logic [LOG2_FFT_POINTS-1:0] LastIdx = LOG2_FFT_POINTS'(FFT_POINTS - 1);

    state_e                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      re_buf_q [FFT_POINTS];
    logic [DATA_WIDTH-1:0]      re_buf_d [FFT_POINTS];
    logic [DATA_WIDTH-1:0]      im_buf_q [FFT_POINTS];
    logic [DATA_WIDTH-1:0]      im_buf_d [FFT_POINTS];
    logic                       bin_valid_q, bin_valid_d;
    logic [LOG2_FFT_POINTS-1:0] bin_index_q, bin_index_d;
    logic [MAG_WIDTH-1:0]       bin_mag_q, bin_mag_d;
    logic                       bin_last_q, bin_last_d;
    logic [LOG2_FFT_POINTS-1:0] run_idx_q, run_idx_d;
    logic [MAG_WIDTH-1:0]       run_mag_q, run_mag_d;
    logic                       peak_valid_q, peak_valid_d;
    logic [LOG2_FFT_POINTS-1:0] peak_index_q, peak_index_d;
    logic [MAG_WIDTH-1:0]       peak_mag_q, peak_mag_d;
    logic                       busy_q, busy_d;
    logic                       frame_dropped_q, frame_dropped_d;

    // Shared squarer pair, always looking at the bin that would be loaded next.
    logic [LOG2_FFT_POINTS-1:0] sel_idx;
    logic [DATA_WIDTH-1:0]      re_sel, im_sel;
    logic signed [2*DATA_WIDTH-1:0] re_ext, im_ext;
    logic [2*DATA_WIDTH-1:0]    re_sq, im_sq;
    logic [MAG_WIDTH-1:0]       mag_sel;

    always_comb begin
        sel_idx = (state_q == StPrep) ? '0 : LOG2_FFT_POINTS'(bin_index_q + 1'b1);
        re_sel  = re_buf_q[sel_idx];
        im_sel  = im_buf_q[sel_idx];
        re_ext  = {{DATA_WIDTH{re_sel[DATA_WIDTH-1]}}, re_sel};
        im_ext  = {{DATA_WIDTH{im_sel[DATA_WIDTH-1]}}, im_sel};
        re_sq   = $unsigned(re_ext * re_ext);
        im_sq   = $unsigned(im_ext * im_ext);
        mag_sel = MAG_WIDTH'(re_sq + im_sq);
    end

    always_comb begin
        state_d         = state_q;
        re_buf_d        = re_buf_q;
        im_buf_d        = im_buf_q;
        bin_valid_d     = bin_valid_q;
        bin_index_d     = bin_index_q;
        bin_mag_d       = bin_mag_q;
        bin_last_d      = bin_last_q;
        run_idx_d       = run_idx_q;
        run_mag_d       = run_mag_q;
        peak_valid_d    = 1'b0;
        peak_index_d    = peak_index_q;
        peak_mag_d      = peak_mag_q;
        busy_d          = busy_q;
        frame_dropped_d = frame_valid && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (frame_valid) begin
                    for (int i = 0; i < FFT_POINTS; i++) begin
                        re_buf_d[i] = frame_real[i*DATA_WIDTH +: DATA_WIDTH];
                        im_buf_d[i] = frame_imag[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    busy_d  = 1'b1;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                bin_index_d = '0;
                bin_mag_d   = mag_sel;
                bin_last_d  = (FFT_POINTS == 1);
                bin_valid_d = 1'b1;
                run_idx_d   = '0;
                run_mag_d   = mag_sel;
                state_d     = StStream;
            end
            StStream: begin
                if (bin_valid_q && bin_ready) begin
                    if (bin_last_q) begin
                        bin_valid_d  = 1'b0;
                        bin_last_d   = 1'b0;
                        busy_d       = 1'b0;
                        peak_index_d = run_idx_q;
                        peak_mag_d   = run_mag_q;
                        peak_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        bin_index_d = sel_idx;
                        bin_mag_d   = mag_sel;
                        bin_last_d  = (sel_idx == LastIdx);
                        // Strictly greater, so ties keep the lower index.
                        if (mag_sel > run_mag_q) begin
                            run_idx_d = sel_idx;
                            run_mag_d = mag_sel;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            for (int i = 0; i < FFT_POINTS; i++) begin
                re_buf_q[i] <= '0;
                im_buf_q[i] <= '0;
            end
            bin_valid_q     <= 1'b0;
            bin_index_q     <= '0;
            bin_mag_q       <= '0;
            bin_last_q      <= 1'b0;
            run_idx_q       <= '0;
            run_mag_q       <= '0;
            peak_valid_q    <= 1'b0;
            peak_index_q    <= '0;
            peak_mag_q      <= '0;
            busy_q          <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            re_buf_q        <= re_buf_d;
            im_buf_q        <= im_buf_d;
            bin_valid_q     <= bin_valid_d;
            bin_index_q     <= bin_index_d;
            bin_mag_q       <= bin_mag_d;
            bin_last_q      <= bin_last_d;
            run_idx_q       <= run_idx_d;
            run_mag_q       <= run_mag_d;
            peak_valid_q    <= peak_valid_d;
            peak_index_q    <= peak_index_d;
            peak_mag_q      <= peak_mag_d;
            busy_q          <= busy_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    assign bin_valid     = bin_valid_q;
    assign bin_index     = bin_index_q;
    assign bin_mag       = bin_mag_q;
    assign bin_last      = bin_last_q;
    assign peak_valid    = peak_valid_q;
    assign peak_index    = peak_index_q;
    assign peak_mag      = peak_mag_q;
    assign busy          = busy_q;
    assign frame_dropped = frame_dropped_q;

endmodule
